// File: rtl/acc_unit.sv
// acc_unit: accumulates a programmed number of adder-tree partial sums
// into one running total, then offers it downstream via valid/ready.
module acc_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             in_ready_q, out_valid_q, busy_q;
  logic [WIDTH-1:0] sum;

  // Full-width wrapping sum of the running total and the incoming beat.
  assign sum = acc_q + in_data;

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    out_data_d = out_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d      = '0;
          out_data_d = '0;
          if (len != '0) begin
            rem_d   = len;
            state_d = S_ACC;
          end else begin
            rem_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_ACC: begin
        if (in_valid) begin
          acc_d = sum;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            out_data_d = sum;
            state_d    = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; flags are decoded from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= (state_d == S_ACC);
      out_valid_q <= (state_d == S_DONE);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_acc_unit.sv
// Testbench for acc_unit: directed scenarios plus randomized jobs checked
// against a plain-arithmetic expected total.
module tb_acc_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        busy;

  int checks;
  int failures;

  logic [31:0] d_arr [0:15];
  int          g_arr [0:15];

  acc_unit #(.WIDTH(32), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"},  out_data,       32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  // Runs one job of L beats from d_arr with g_arr stall cycles before each
  // beat, then holds out_ready low for bp cycles before the handshake.
  // poke pulses a conflicting start during stalls and during the handshake.
  task automatic run_job(input int L, input int bp, input bit poke);
    logic [31:0] exp;
    exp = 32'd0;
    for (int i = 0; i < L; i++) exp = exp + d_arr[i];

    start = 1'b1;
    len   = 16'(L);
    step();
    start = 1'b0;
    len   = 16'd0;
    chk("start_busy",      32'(busy),      32'd1);
    chk("start_in_ready",  32'(in_ready),  32'(L != 0));
    chk("start_out_valid", 32'(out_valid), 32'(L == 0));

    for (int i = 0; i < L; i++) begin
      for (int g = 0; g < g_arr[i]; g++) begin
        in_valid = 1'b0;
        if (poke) begin
          start = 1'b1;
          len   = 16'd7;
        end
        step();
        start = 1'b0;
        len   = 16'd0;
        chk("stall_in_ready",  32'(in_ready),  32'd1);
        chk("stall_out_valid", 32'(out_valid), 32'd0);
      end
      in_valid = 1'b1;
      in_data  = d_arr[i];
      step();
      in_valid = 1'b0;
    end

    chk("done_out_valid", 32'(out_valid), 32'd1);
    chk("done_out_data",  out_data,       exp);
    chk("done_in_ready",  32'(in_ready),  32'd0);

    for (int b = 0; b < bp; b++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = $urandom;
      step();
      in_valid = 1'b0;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data",  out_data,       exp);
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_busy",      32'(busy),      32'd1);
    end

    out_ready = 1'b1;
    if (poke) begin
      start = 1'b1;
      len   = 16'd7;
    end
    step();
    out_ready = 1'b0;
    start     = 1'b0;
    len       = 16'd0;
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_busy",      32'(busy),      32'd0);
    chk("idle_in_ready",  32'(in_ready),  32'd0);
    chk("idle_out_data",  out_data,       exp);

    if (poke) begin
      step();
      chk("post_idle_busy",      32'(busy),      32'd0);
      chk("post_idle_out_valid", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    int L;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = 16'd0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      d_arr[i] = 32'd0;
      g_arr[i] = 0;
    end

    // Reset state
    #12;
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    step();
    chk_zero_outputs("post_reset_idle");

    // Basic sum
    d_arr[0] = 32'd1; d_arr[1] = 32'd2; d_arr[2] = 32'd3; d_arr[3] = 32'd4;
    run_job(4, 0, 1'b0);

    // Stalls and backpressure
    d_arr[0] = 32'd100; d_arr[1] = 32'd200; d_arr[2] = 32'd300;
    g_arr[0] = 0; g_arr[1] = 2; g_arr[2] = 1;
    run_job(3, 5, 1'b0);
    for (int i = 0; i < 16; i++) g_arr[i] = 0;

    // Wrap-around
    d_arr[0] = 32'hFFFF_FFFF; d_arr[1] = 32'h0000_0002;
    run_job(2, 0, 1'b0);
    chk("wrap_value", out_data, 32'h0000_0001);

    // Negative operand
    d_arr[0] = 32'hFFFF_FFFB; d_arr[1] = 32'd3;
    run_job(2, 1, 1'b0);
    chk("neg_value", out_data, 32'hFFFF_FFFE);

    // Zero-length job
    run_job(0, 2, 1'b0);

    // Start pulsed during ACC and at the handshake is ignored
    d_arr[0] = 32'd11; d_arr[1] = 32'd22;
    g_arr[1] = 2;
    run_job(2, 0, 1'b1);
    g_arr[1] = 0;

    // Reset mid-job after 3 of 5 beats
    start = 1'b1;
    len   = 16'd5;
    step();
    start = 1'b0;
    len   = 16'd0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'd1000 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_zero_outputs("midjob_reset");
    step();
    chk_zero_outputs("midjob_reset_held");
    rst_n = 1'b1;
    d_arr[0] = 32'd9;
    run_job(1, 0, 1'b0);
    chk("after_reset_value", out_data, 32'd9);

    // Randomized jobs
    for (int j = 0; j < 25; j++) begin
      L = int'($urandom_range(0, 8));
      for (int i = 0; i < 16; i++) begin
        d_arr[i] = $urandom;
        g_arr[i] = int'($urandom_range(0, 2));
      end
      run_job(L, int'($urandom_range(0, 3)), 1'(($urandom & 32'd3) == 32'd0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
